// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen-timer control stage: state encoding
// and the mod-60 BCD digit-pair increment.
package timer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_ALARM = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        ALARM = ST_ALARM
    } state_t;

    // {tens, ones} BCD increment: x9 -> (x+1)0, 59 -> 00.
    function automatic logic [7:0] bcd60_inc(input logic [7:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = value[7:4];
        ones = value[3:0];
        if (ones >= 4'd9) begin
            ones = 4'd0;
            if (tens >= 4'd5) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd60_set_reg.sv
// Two-digit BCD set register (00..59) with increment and clear; clear wins.
module bcd60_set_reg
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       inc,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0] value_reg;
    logic [7:0] value_next;

    always_comb begin
        value_next = value_reg;
        if (clear) begin
            value_next = 8'h00;
        end else if (inc) begin
            value_next = bcd60_inc(value_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            value_reg <= 8'h00;
        end else begin
            value_reg <= value_next;
        end
    end

    assign tens = value_reg[7:4];
    assign ones = value_reg[3:0];

endmodule

// File: rtl/cook_timer_ctrl.sv
// Kitchen-timer control: edits the MM:SS set value, loads and gates the
// external BCD down counters, and raises a timed alarm at 00:00.
module cook_timer_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_sec,
    input  logic       btn_start,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       btn_clear,
    input  logic [3:0] cnt_sec1,
    input  logic [3:0] cnt_sec10,
    input  logic [3:0] cnt_min1,
    input  logic [3:0] cnt_min10,
    output logic [3:0] set_sec1,
    output logic [3:0] set_sec10,
    output logic [3:0] set_min1,
    output logic [3:0] set_min10,
    output logic       load_enable,
    output logic       sec_tick_out,
    output logic       running,
    output logic       alarm
);

    localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC - 1);

    state_t     state_reg;
    logic [5:0] alarm_cnt_reg;

    logic zero;
    logic set_nonzero;
    logic in_idle;
    logic edit_clear;
    logic edit_sec;
    logic edit_min;

    assign zero        = (cnt_sec1 == 4'd0) && (cnt_sec10 == 4'd0) &&
                         (cnt_min1 == 4'd0) && (cnt_min10 == 4'd0);
    assign set_nonzero = |{set_sec1, set_sec10, set_min1, set_min10};
    assign in_idle     = (state_reg == IDLE);

    // Editing only in IDLE; a clear or start in the same cycle drops increments.
    assign edit_clear = in_idle & btn_clear;
    assign edit_sec   = in_idle & ~btn_clear & ~btn_start & btn_sec;
    assign edit_min   = in_idle & ~btn_clear & ~btn_start & btn_min;

    bcd60_set_reg u_set_sec (
        .clk     (clk),
        .reset_p (reset_p),
        .inc     (edit_sec),
        .clear   (edit_clear),
        .tens    (set_sec10),
        .ones    (set_sec1)
    );

    bcd60_set_reg u_set_min (
        .clk     (clk),
        .reset_p (reset_p),
        .inc     (edit_min),
        .clear   (edit_clear),
        .tens    (set_min10),
        .ones    (set_min1)
    );

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_reg     <= IDLE;
            alarm_cnt_reg <= 6'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    alarm_cnt_reg <= 6'd0;
                    if (!btn_clear && btn_start && set_nonzero) begin
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    state_reg <= RUN;
                end
                RUN: begin
                    alarm_cnt_reg <= 6'd0;
                    if (btn_clear) begin
                        state_reg <= IDLE;
                    end else if (zero) begin
                        state_reg <= ALARM;
                    end else if (btn_start) begin
                        state_reg <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (btn_clear) begin
                        state_reg <= IDLE;
                    end else if (btn_start) begin
                        state_reg <= RUN;
                    end
                end
                ALARM: begin
                    if (btn_clear) begin
                        state_reg     <= IDLE;
                        alarm_cnt_reg <= 6'd0;
                    end else if (tick_sec) begin
                        if (alarm_cnt_reg >= ALARM_LAST) begin
                            state_reg     <= IDLE;
                            alarm_cnt_reg <= 6'd0;
                        end else begin
                            alarm_cnt_reg <= alarm_cnt_reg + 6'd1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    alarm_cnt_reg <= 6'd0;
                end
            endcase
        end
    end

    assign load_enable  = (state_reg == LOAD);
    assign running      = (state_reg == LOAD) || (state_reg == RUN);
    assign alarm        = (state_reg == ALARM);
    // Same-cycle forwarding so the counters decrement on the real tick.
    assign sec_tick_out = tick_sec & (state_reg == RUN) & ~zero;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl with a behavioural MM:SS down-counter pair.
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       tick_sec = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_sec = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] cnt_sec1 = 4'd0;
    logic [3:0] cnt_sec10 = 4'd0;
    logic [3:0] cnt_min1 = 4'd0;
    logic [3:0] cnt_min10 = 4'd0;
    logic [3:0] set_sec1, set_sec10, set_min1, set_min10;
    logic       load_enable, sec_tick_out, running, alarm;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cook_timer_ctrl #(.ALARM_SEC(10)) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .tick_sec     (tick_sec),
        .btn_start    (btn_start),
        .btn_sec      (btn_sec),
        .btn_min      (btn_min),
        .btn_clear    (btn_clear),
        .cnt_sec1     (cnt_sec1),
        .cnt_sec10    (cnt_sec10),
        .cnt_min1     (cnt_min1),
        .cnt_min10    (cnt_min10),
        .set_sec1     (set_sec1),
        .set_sec10    (set_sec10),
        .set_min1     (set_min1),
        .set_min10    (set_min10),
        .load_enable  (load_enable),
        .sec_tick_out (sec_tick_out),
        .running      (running),
        .alarm        (alarm)
    );

    // Behavioural model of the loadable MM:SS BCD down counters.
    always @(posedge clk) begin
        if (load_enable) begin
            cnt_sec1  <= set_sec1;
            cnt_sec10 <= set_sec10;
            cnt_min1  <= set_min1;
            cnt_min10 <= set_min10;
        end else if (sec_tick_out) begin
            if (cnt_sec1 != 4'd0) begin
                cnt_sec1 <= cnt_sec1 - 4'd1;
            end else begin
                cnt_sec1 <= 4'd9;
                if (cnt_sec10 != 4'd0) begin
                    cnt_sec10 <= cnt_sec10 - 4'd1;
                end else begin
                    cnt_sec10 <= 4'd5;
                    if (cnt_min1 != 4'd0) begin
                        cnt_min1 <= cnt_min1 - 4'd1;
                    end else begin
                        cnt_min1  <= 4'd9;
                        cnt_min10 <= cnt_min10 - 4'd1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock; inputs are released 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        btn_start = 1'b0;
        btn_sec   = 1'b0;
        btn_min   = 1'b0;
        btn_clear = 1'b0;
        tick_sec  = 1'b0;
    endtask

    function automatic logic [15:0] set_val();
        return {set_min10, set_min1, set_sec10, set_sec1};
    endfunction

    function automatic logic [15:0] cnt_val();
        return {cnt_min10, cnt_min1, cnt_sec10, cnt_sec1};
    endfunction

    function automatic logic [3:0] flags();
        return {load_enable, sec_tick_out, running, alarm};
    endfunction

    initial begin
        cyc();
        cyc();
        chk("reset_flags", {12'd0, flags()}, 16'h0000);
        chk("reset_set", set_val(), 16'h0000);
        reset_p = 1'b0;
        cyc();

        for (int i = 0; i < 61; i++) begin
            btn_sec = 1'b1;
            cyc();
        end
        chk("sec_x61", set_val(), 16'h0001);
        for (int i = 0; i < 3; i++) begin
            btn_min = 1'b1;
            cyc();
        end
        chk("min_x3", set_val(), 16'h0301);
        btn_clear = 1'b1;
        cyc();
        chk("clear_set", set_val(), 16'h0000);

        // Start with 00:00 is ignored.
        btn_start = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("start_zero_flags", {12'd0, flags()}, 16'h0000);
            cyc();
        end

        // Run 00:03 to alarm.
        for (int i = 0; i < 3; i++) begin
            btn_sec = 1'b1;
            cyc();
        end
        chk("set_0003", set_val(), 16'h0003);
        btn_start = 1'b1;
        cyc();
        chk("load_cycle", {12'd0, flags()}, 16'h000a);
        cyc();
        chk("run_after_load", {12'd0, flags()}, 16'h0002);
        chk("counters_loaded", cnt_val(), 16'h0003);
        for (int i = 0; i < 3; i++) begin
            tick_sec = 1'b1;
            #1;
            chk("run_tick_fwd", {15'd0, sec_tick_out}, 16'h0001);
            cyc();
        end
        chk("counters_zero", cnt_val(), 16'h0000);
        chk("still_run_at_zero", {12'd0, flags()}, 16'h0002);
        tick_sec = 1'b1;
        #1;
        chk("zero_tick_blocked", {15'd0, sec_tick_out}, 16'h0000);
        cyc();
        chk("alarm_rise", {12'd0, flags()}, 16'h0001);
        for (int i = 1; i <= 10; i++) begin
            tick_sec = 1'b1;
            cyc();
            chk($sformatf("alarm_tick%0d", i), {15'd0, alarm}, (i < 10) ? 16'h0001 : 16'h0000);
        end
        chk("set_retained", set_val(), 16'h0003);

        // Pause / resume with 00:05.
        btn_sec = 1'b1;
        cyc();
        btn_sec = 1'b1;
        cyc();
        btn_start = 1'b1;
        cyc();
        cyc();
        chk("load_0005", cnt_val(), 16'h0005);
        tick_sec = 1'b1;
        cyc();
        tick_sec  = 1'b1;
        btn_start = 1'b1;
        #1;
        chk("start_tick_fwd", {15'd0, sec_tick_out}, 16'h0001);
        cyc();
        chk("paused_flags", {12'd0, flags()}, 16'h0000);
        chk("paused_cnt", cnt_val(), 16'h0003);
        for (int i = 0; i < 5; i++) begin
            tick_sec = 1'b1;
            #1;
            chk("pause_tick_blocked", {15'd0, sec_tick_out}, 16'h0000);
            cyc();
        end
        btn_start = 1'b1;
        cyc();
        tick_sec = 1'b1;
        #1;
        chk("resume_tick_fwd", {15'd0, sec_tick_out}, 16'h0001);
        cyc();
        chk("resume_cnt", cnt_val(), 16'h0002);
        btn_start = 1'b1;
        cyc();
        btn_clear = 1'b1;
        cyc();
        btn_sec = 1'b1;
        cyc();
        chk("pause_clear_idle_edit", set_val(), 16'h0006);
        chk("pause_clear_flags", {12'd0, flags()}, 16'h0000);

        // Clear during alarm: 00:06 run down.
        btn_start = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 6; i++) begin
            tick_sec = 1'b1;
            cyc();
        end
        cyc();
        chk("alarm2_rise", {15'd0, alarm}, 16'h0001);
        tick_sec  = 1'b1;
        btn_start = 1'b1;
        cyc();
        chk("alarm_start_ignored", {15'd0, alarm}, 16'h0001);
        btn_clear = 1'b1;
        cyc();
        chk("alarm_clear", {12'd0, flags()}, 16'h0000);

        // Reset in RUN.
        btn_start = 1'b1;
        cyc();
        cyc();
        chk("run_before_reset", {15'd0, running}, 16'h0001);
        reset_p = 1'b1;
        cyc();
        chk("reset_run_flags", {12'd0, flags()}, 16'h0000);
        chk("reset_run_set", set_val(), 16'h0000);
        reset_p = 1'b0;

        // Reset in ALARM with 00:01.
        btn_sec = 1'b1;
        cyc();
        btn_start = 1'b1;
        cyc();
        cyc();
        tick_sec = 1'b1;
        cyc();
        cyc();
        chk("alarm3_rise", {15'd0, alarm}, 16'h0001);
        reset_p = 1'b1;
        cyc();
        chk("reset_alarm_flags", {12'd0, flags()}, 16'h0000);
        chk("reset_alarm_set", set_val(), 16'h0000);
        reset_p = 1'b0;
        cyc();
        chk("post_reset_flags", {12'd0, flags()}, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
